// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and defaults for the PWM ramp sequencer
package pwm_pkg;

  localparam int PWM_WIDTH      = 8;
  localparam int PWM_PERIOD_RST = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RAMP = 2'd2
  } pwm_state_e;

endpackage

// File: rtl/pwm_step_unit.sv
// rtl/pwm_step_unit.sv - combinational saturating up/down duty step
module pwm_step_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] duty,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] next_duty
);

  logic [WIDTH:0] duty_w;
  logic [WIDTH:0] target_w;
  logic [WIDTH:0] step_w;
  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] down_lim;

  assign duty_w   = {1'b0, duty};
  assign target_w = {1'b0, target};
  assign step_w   = {1'b0, step};
  assign up_sum   = duty_w + step_w;
  assign down_lim = target_w + step_w;

  // One extra bit keeps the sums from wrapping, so saturation lands exactly on target.
  always_comb begin
    next_duty = target;
    if (step != '0) begin
      if (duty < target) begin
        if (up_sum < target_w) begin
          next_duty = up_sum[WIDTH-1:0];
        end
      end else if (duty > target) begin
        if (duty_w >= down_lim) begin
          next_duty = duty - step;
        end
      end
    end
  end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// rtl/pwm_ramp_ctrl.sv - period/duty sequencer committing changes on PWM period boundaries
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int               WIDTH      = PWM_WIDTH,
  parameter logic [WIDTH-1:0] PERIOD_RST = WIDTH'(PWM_PERIOD_RST)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] cnt_q,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_period,
  input  logic [WIDTH-1:0] cfg_target,
  input  logic [WIDTH-1:0] cfg_step,
  input  logic             abort,
  output logic [WIDTH-1:0] limit_o,
  output logic [WIDTH-1:0] duty_o,
  output logic             busy,
  output logic             done
);

  pwm_state_e state_q;
  pwm_state_e state_d;

  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] duty_q;
  logic             done_q;
  logic             done_d;

  logic [WIDTH-1:0] sh_period;
  logic [WIDTH-1:0] sh_target;
  logic [WIDTH-1:0] sh_step;
  logic [WIDTH-1:0] clamped_target;
  logic [WIDTH-1:0] step_next;

  logic bnd;
  logic latch_cfg;
  logic commit_limit;
  logic apply_step;

  assign bnd = (cnt_q == limit_q);

  // A target above the period would never be reached by the comparator anyway.
  assign clamped_target = (cfg_target > cfg_period) ? cfg_period : cfg_target;

  pwm_step_unit #(
    .WIDTH(WIDTH)
  ) u_step (
    .duty     (duty_q),
    .target   (sh_target),
    .step     (sh_step),
    .next_duty(step_next)
  );

  always_comb begin
    state_d      = state_q;
    cfg_ready    = 1'b0;
    latch_cfg    = 1'b0;
    commit_limit = 1'b0;
    apply_step   = 1'b0;
    done_d       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          latch_cfg = 1'b1;
          state_d   = ST_ARM;
        end
      end
      ST_ARM: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bnd) begin
          commit_limit = 1'b1;
          state_d      = ST_RAMP;
        end
      end
      ST_RAMP: begin
        // abort outranks a coincident boundary: duty stays frozen.
        if (abort) begin
          state_d = ST_IDLE;
        end else if (bnd) begin
          apply_step = 1'b1;
          if (step_next == sh_target) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      limit_q   <= PERIOD_RST;
      duty_q    <= '0;
      done_q    <= 1'b0;
      sh_period <= '0;
      sh_target <= '0;
      sh_step   <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (latch_cfg) begin
        sh_period <= cfg_period;
        sh_target <= clamped_target;
        sh_step   <= cfg_step;
      end
      if (commit_limit) begin
        limit_q <= sh_period;
      end
      if (apply_step) begin
        duty_q <= step_next;
      end
    end
  end

  assign limit_o = limit_q;
  assign duty_o  = duty_q;
  assign done    = done_q;
  assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb/tb_pwm_ramp_ctrl.sv - directed self-checking bench for pwm_ramp_ctrl
module tb_pwm_ramp_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] cnt;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_period;
  logic [7:0] cfg_target;
  logic [7:0] cfg_step;
  logic       abort;
  logic [7:0] limit_o;
  logic [7:0] duty_o;
  logic       busy;
  logic       done;

  int checks;
  int errors;
  int done_cnt;
  int d0;

  pwm_ramp_ctrl dut (
    .CLK       (clk),
    .RST       (rst),
    .cnt_q     (cnt),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_period(cfg_period),
    .cfg_target(cfg_target),
    .cfg_step  (cfg_step),
    .abort     (abort),
    .limit_o   (limit_o),
    .duty_o    (duty_o),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PWM counter model: 0..limit_o inclusive, then wrap
  always @(posedge clk) begin
    if (rst) cnt <= 8'd0;
    else if (cnt >= limit_o) cnt <= 8'd0;
    else cnt <= cnt + 8'd1;
  end

  initial done_cnt = 0;
  always @(negedge clk) if (done === 1'b1) done_cnt = done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_bnd_pre();
    int n;
    n = 0;
    while (!(cnt == limit_o) && n < 64) begin
      cycle();
      n++;
    end
    checks++;
    assert (n < 64) else begin
      errors++;
      $error("FAIL bnd_timeout observed=%0d expected=<64", n);
    end
  endtask

  task automatic next_bnd();
    wait_bnd_pre();
    cycle();
  endtask

  task automatic send_cfg(input logic [7:0] p, input logic [7:0] t, input logic [7:0] s);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_target = t;
    cfg_step   = s;
    cycle();
    cfg_valid  = 1'b0;
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    cfg_valid  = 1'b0;
    cfg_period = 8'd0;
    cfg_target = 8'd0;
    cfg_step   = 8'd0;
    abort      = 1'b0;
    @(negedge clk);
    cycle();
    cycle();
    rst = 1'b0;

    chk("rst_limit", limit_o, 5);
    chk("rst_duty", duty_o, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    d0 = done_cnt;
    repeat (20) cycle();
    chk("idle_limit", limit_o, 5);
    chk("idle_done_cnt", done_cnt - d0, 0);

    // ramp up 0 -> 6 by 2 with period 9
    d0 = done_cnt;
    send_cfg(8'd9, 8'd6, 8'd2);
    chk("up_busy", busy, 1);
    chk("up_ready", cfg_ready, 0);
    next_bnd();
    chk("up_limit", limit_o, 9);
    chk("up_duty0", duty_o, 0);
    next_bnd();
    chk("up_duty2", duty_o, 2);
    chk("up_nodone", done, 0);
    next_bnd();
    chk("up_duty4", duty_o, 4);
    next_bnd();
    chk("up_duty6", duty_o, 6);
    chk("up_done", done, 1);
    chk("up_busy_fall", busy, 0);
    chk("up_ready_rise", cfg_ready, 1);
    cycle();
    chk("up_done_low", done, 0);
    chk("up_done_cnt", done_cnt - d0, 1);

    // clamp target 200 -> 9, step 0 jumps
    d0 = done_cnt;
    send_cfg(8'd9, 8'd200, 8'd0);
    next_bnd();
    chk("clamp_arm_duty", duty_o, 6);
    next_bnd();
    chk("clamp_duty", duty_o, 9);
    chk("clamp_done", done, 1);
    cycle();
    chk("clamp_done_cnt", done_cnt - d0, 1);

    // preset duty 6, then ramp down to 1 by 4
    send_cfg(8'd9, 8'd6, 8'd0);
    next_bnd();
    next_bnd();
    chk("pre_duty6", duty_o, 6);
    cycle();
    d0 = done_cnt;
    send_cfg(8'd9, 8'd1, 8'd4);
    next_bnd();
    next_bnd();
    chk("down_duty2", duty_o, 2);
    cfg_valid  = 1'b1;
    cfg_period = 8'd3;
    cfg_target = 8'd0;
    cfg_step   = 8'd0;
    cycle();
    chk("down_ready0_a", cfg_ready, 0);
    cycle();
    chk("down_ready0_b", cfg_ready, 0);
    cfg_valid = 1'b0;
    next_bnd();
    chk("down_duty1", duty_o, 1);
    chk("down_done", done, 1);
    cycle();
    chk("down_done_cnt", done_cnt - d0, 1);
    chk("down_limit_kept", limit_o, 9);

    // abort coincident with a RAMP boundary
    d0 = done_cnt;
    send_cfg(8'd9, 8'd8, 8'd1);
    next_bnd();
    next_bnd();
    chk("abort_pre_duty", duty_o, 2);
    wait_bnd_pre();
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("abort_duty", duty_o, 2);
    chk("abort_busy", busy, 0);
    chk("abort_ready", cfg_ready, 1);
    repeat (25) cycle();
    chk("abort_duty_hold", duty_o, 2);
    chk("abort_done_cnt", done_cnt - d0, 0);

    // abort in ARM discards the latched period
    send_cfg(8'd4, 8'd3, 8'd1);
    abort = 1'b1;
    cycle();
    abort = 1'b0;
    chk("arm_abort_busy", busy, 0);
    repeat (15) cycle();
    chk("arm_abort_limit", limit_o, 9);
    chk("arm_abort_duty", duty_o, 2);

    // reset mid-RAMP, then a fresh configuration
    send_cfg(8'd7, 8'd7, 8'd1);
    next_bnd();
    chk("mid_limit", limit_o, 7);
    next_bnd();
    chk("mid_duty3", duty_o, 3);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    chk("mrst_limit", limit_o, 5);
    chk("mrst_duty", duty_o, 0);
    chk("mrst_ready", cfg_ready, 1);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    d0 = done_cnt;
    send_cfg(8'd6, 8'd4, 8'd3);
    next_bnd();
    chk("fresh_limit", limit_o, 6);
    next_bnd();
    chk("fresh_duty3", duty_o, 3);
    next_bnd();
    chk("fresh_duty4", duty_o, 4);
    chk("fresh_done", done, 1);
    cycle();
    chk("fresh_done_cnt", done_cnt - d0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_ramp_ctrl.md
# pwm_ramp_ctrl

Sequencer for the PWM datapath (free-running `counter` plus `<=` comparator). It owns the counter's `LIMIT` and the comparator's duty threshold. It accepts new period/duty targets over a valid/ready handshake and commits them only at period boundaries, so the output never glitches. It ramps duty toward the target by a programmable step once per PWM period, then signals completion.

## Interface
- `WIDTH`, 8, width of counter value, limit and duty
- `PERIOD_RST`, 8'd5, limit value driven out of reset
- `CLK`  in  1  single clock; all logic on rising edge
- `RST`  in  1  synchronous, active-high reset
- `cnt_q`  in  WIDTH  current counter value `Q` from the PWM counter
- `cfg_valid`  in  1  configuration request
- `cfg_ready`  out  1  block can accept configuration
- `cfg_period`  in  WIDTH  new counter limit
- `cfg_target`  in  WIDTH  target duty threshold
- `cfg_step`  in  WIDTH  duty increment per period; 0 means jump
- `abort`  in  1  stop ramp and freeze duty at its current value
- `limit_o`  out  WIDTH  drives counter `LIMIT`
- `duty_o`  out  WIDTH  drives comparator `b` (PWM high while `Q <= duty_o`)
- `busy`  out  1  ramp or pending commit in progress
- `done`  out  1  one-cycle pulse when `duty_o` reaches target

## Operation
- Counter contract: counts 0..`limit_o` inclusive, then wraps to 0.
- Boundary: `bnd = (cnt_q == limit_o)`. Commits take effect on the edge where `bnd` is 1, so the new values apply from count 0.
- States:
  - IDLE: `cfg_ready`=1, `busy`=0. A handshake (`cfg_valid && cfg_ready`) latches `cfg_*` into shadow registers, then goes to ARM.
  - ARM: on `bnd`, `limit_o` <= shadow period, then goes to RAMP.
  - RAMP: one step applied on each `bnd`. When `duty_o` equals the target after the update, `done` pulses and the state goes to IDLE.
- Target clamp: effective target = min(`cfg_target`, `cfg_period`), computed at latch time.
- Step arithmetic, in WIDTH+1 bits, saturating at target:
  - Up: if `duty + step >= target`, duty becomes target.
  - Down: if `duty < target + step`, duty becomes target.
  - `step`=0: duty becomes target on the first RAMP boundary.
- Target already equal to duty: go through ARM, then RAMP. On the first boundary `done` pulses with no duty change.
- `abort` in ARM or RAMP: next edge goes to IDLE.
  - `duty_o` is frozen. `limit_o` keeps its last committed value, so a period latched in ARM is discarded.
  - No `done` pulse.
  - If `abort` coincides with `bnd`, abort wins and no step or commit happens.
- `cfg_valid` outside IDLE is ignored; `cfg_ready`=0 there.
- Reset mid-ramp: all state returns to reset values on that edge. Shadow registers are cleared.

## Timing
- Reset values: `limit_o`=`PERIOD_RST`, `duty_o`=0, `cfg_ready`=1, `busy`=0, `done`=0, state IDLE.
- Handshake to ARM: 1 cycle. `busy` rises the cycle after acceptance.
- ARM to first limit change: waits for the next `bnd`, at most `limit_o`+1 cycles.
- `duty_o` and `limit_o` are registered and change only on `bnd` edges. They are stable for whole periods.
- `done` is asserted in the cycle after the final-step edge, for exactly one cycle. `busy` falls on that same edge, and `cfg_ready` rises.
- Back-to-back configurations: a new request can be accepted in the cycle `done` is high.

## Structure
- Shared package `pwm_pkg`:
  - state enum (IDLE, ARM, RAMP)
  - `PWM_WIDTH`=8
  - `PWM_PERIOD_RST`=5
- Sub-module `pwm_step_unit`: combinational saturating up/down step with inputs duty, target and step, and output next duty. It is reused by later fade blocks.
- Top holds the FSM, shadow registers and boundary detect. Target size is about 150–250 lines.

## Test plan
- Reset, then idle 20 cycles: expect `limit_o`=5, `duty_o`=0, `cfg_ready`=1, no `done`.
- Configure period 9, target 6, step 2 from duty 0:
  - `limit_o`=9 after the first boundary.
  - `duty_o` goes 2, 4, 6 on three successive boundaries.
  - `done` is a single pulse after the 6 is applied.
- Configure period 9, target 200: target clamps to 9. With step 0, `duty_o`=9 at the first RAMP boundary, giving PWM constantly high.
- Ramp down from 6 to 1 with step 4:
  - Sequence is 2 then 1 (saturated). `done` pulses once.
  - `cfg_valid` asserted mid-ramp is ignored and `cfg_ready` stays 0.
- Assert `abort` in the same cycle as a RAMP boundary:
  - No step; `duty_o` stays at its prior value.
  - Next state is IDLE; `done` never pulses.
- Assert `RST` mid-RAMP: after one edge, all outputs are at reset values. A fresh configuration then works normally.
